elevator_scheduler: RTL and testbench
=====================================

Name: elevator_scheduler

Overview:
Request scheduler for the 4-floor elevator car. It latches hall/car calls into a pending bitmap and chooses the travel direction with a SCAN policy: keep going while calls lie ahead, reverse otherwise. It sequences the car through travel and door phases using internal cycle timers, and publishes floor, direction, motion and door status to the floor-display and motor logic. `emergency` is the system-wide homing reset.

Parameters:
FLOOR_W, 2, floor index width; FLOORS = 2**FLOOR_W (4)
TRAVEL_CYCLES, 8, clock cycles to move one floor (>=2)
DOOR_CYCLES, 4, clock cycles door stays open (>=2)

Ports:
clk  input  1  system clock, rising edge
emergency  input  1  asynchronous, active-high reset; returns the car to floor 0, idle
call_req  input  FLOORS  per-floor call; level or pulse, sampled every cycle
door_hold  input  1  holds the door open while high (only effective in DOOR_OPEN)
cur_floor  output  FLOOR_W  current car floor
dir_up  output  1  1 = up, 0 = down (current or last direction)
moving  output  1  high throughout MOVING
door_open  output  1  high throughout DOOR_OPEN
arrive  output  1  one-cycle pulse when cur_floor changes
pending  output  FLOORS  latched, unserved calls

Behaviour:
- Reset (async, `emergency`=1): state=IDLE, cur_floor=0, dir_up=1, moving=0, door_open=0, arrive=0, pending=0, timer=0. Asserting reset mid-travel or with the door open aborts immediately; all calls are dropped.
- Definitions:
  - ahead = any pending (or same-cycle call_req) bit beyond cur_floor in dir_up's direction.
  - behind = any such bit in the opposite direction.
- Latching: pending <= pending | call_req every cycle, except bit cur_floor in IDLE/DOOR_OPEN (served directly, never latched).
- IDLE:
  - call_req[cur_floor] -> DOOR_OPEN next cycle.
  - else ahead -> MOVING, dir kept.
  - else behind -> MOVING, dir_up flipped in the same edge.
  - else stay.
  - Latency from a call to moving=1 is 1 cycle.
- MOVING:
  - Timer loads TRAVEL_CYCLES-1 on entry and decrements each cycle.
  - When the timer is 0, cur_floor steps ±1 and arrive=1 for one cycle. The new floor is visible TRAVEL_CYCLES cycles after moving rose.
  - If pending or call_req holds the new floor, go to DOOR_OPEN on the same edge; otherwise reload the timer and continue.
  - A call for the floor being departed is latched and served later.
  - Never step below 0 or above FLOORS-1. The SCAN invariant guarantees this; an assertion must check it.
- DOOR_OPEN:
  - Entering clears pending[cur_floor]. Timer loads DOOR_CYCLES-1.
  - door_hold=1 or call_req[cur_floor]=1 reloads the timer.
  - When the timer is 0 and no hold:
    - ahead -> MOVING.
    - elif behind -> flip dir, MOVING.
    - else IDLE.
  - With no hold, door_open is high for exactly DOOR_CYCLES cycles.
- Priority for simultaneous events: emergency > arrival/door expiry decision > call latching. Calls arriving in the decision cycle count toward ahead/behind.
- dir_up changes only on a reversal or reset. moving and door_open are never both 1.

Decomposition:
- Package elevator_pkg:
  - state enum {IDLE, MOVING, DOOR_OPEN}
  - FLOOR_W / FLOORS constants
  - default TRAVEL_CYCLES / DOOR_CYCLES
- Sub-module elevator_timer: loadable down-counter with load, en, load value and zero flag.
  - Shared by the travel and door phases.
  - Width = clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)).
- The ahead/behind mask logic stays inline as combinational logic.

Test Plan:
1. Reset: pulse emergency asynchronously mid-cycle -> outputs immediately cur_floor=0, dir_up=1, moving=0, door_open=0, pending=0.
2. Single call: idle at 0, call_req=0100 for 1 cycle at T -> moving=1 at T+1; arrive with cur_floor=1 at T+9 (no stop); cur_floor=2 and arrive at T+17; door_open T+17..T+20; pending=0; IDLE at T+21.
3. SCAN: car at floor 1 moving up toward 3, then call_req=0101 -> stops at 2, then 3, reverses (dir_up=0), passes 2 and 1 without stopping, stops at 0; final pending=0.
4. Same-floor call: idle at floor 0, call_req=0001 -> door_open=1 next cycle for 4 cycles; pending stays 0000; moving never rises.
5. Door hold: door_hold high for 10 cycles during DOOR_OPEN -> door_open stays 1; it drops exactly 4 cycles after door_hold falls.
6. Emergency mid-travel: car moving 2->3, emergency pulsed with pending=1001 -> immediate reset values, pending=0, no arrive pulse.

Source files
------------

// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the 4-floor elevator request scheduler:
//   - FLOOR_W / FLOORS : floor index width and number of floors
//   - DEFAULT_TRAVEL_CYCLES / DEFAULT_DOOR_CYCLES : default phase lengths
//   - state_t : scheduler state encoding
// -----------------------------------------------------------------------------
package elevator_pkg;

    localparam int FLOOR_W = 2;
    localparam int FLOORS  = 1 << FLOOR_W;

    localparam int DEFAULT_TRAVEL_CYCLES = 8;
    localparam int DEFAULT_DOOR_CYCLES   = 4;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DOOR_OPEN
    } state_t;

endpackage

// File: rtl/elevator_timer.sv
// -----------------------------------------------------------------------------
// elevator_timer
// Loadable down-counter shared by the travel and door phases. It saturates
// at zero, so the scheduler can simply leave it enabled.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset (count -> 0)
//   load       : load load_value this cycle (wins over en)
//   en         : decrement by one when non-zero
//   load_value : value to load
//   zero       : high while the count is zero
// -----------------------------------------------------------------------------
module elevator_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_scheduler
// SCAN request scheduler for a 4-floor elevator car. Calls are latched into
// a pending bitmap; the car keeps its direction while calls lie ahead and
// reverses otherwise, stepping through travel and door phases timed by a
// shared down-counter.
// Ports:
//   clk       : system clock, rising edge
//   emergency : asynchronous active-high reset, homes the car to floor 0
//   call_req  : per-floor call (level or pulse), sampled every cycle
//   door_hold : keeps the door open while high (DOOR_OPEN only)
//   cur_floor : current car floor
//   dir_up    : 1 = up, 0 = down (current or last direction)
//   moving    : high throughout MOVING
//   door_open : high throughout DOOR_OPEN
//   arrive    : one-cycle pulse when cur_floor changes
//   pending   : latched, unserved calls
// -----------------------------------------------------------------------------
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = DEFAULT_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEFAULT_DOOR_CYCLES
) (
    input  logic               clk,
    input  logic               emergency,
    input  logic [FLOORS-1:0]  call_req,
    input  logic               door_hold,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic               arrive,
    output logic [FLOORS-1:0]  pending
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES);
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

    state_t               state;
    logic [FLOORS-1:0]    req;
    logic [FLOORS-1:0]    latch_mask;
    logic [FLOORS-1:0]    clear_mask;
    logic [FLOORS-1:0]    pending_next;
    logic                 above;
    logic                 below;
    logic                 ahead;
    logic                 behind;
    logic                 here_call;
    logic                 door_busy;
    logic                 stop_next;
    logic                 step;
    logic                 open_here;
    logic                 start_idle;
    logic                 door_done;
    logic [FLOOR_W-1:0]   next_floor;
    logic                 timer_load;
    logic                 timer_zero;
    logic [TIMER_W-1:0]   timer_value;

    // Same-cycle calls are folded into the ahead/behind view so a call that
    // arrives in a decision cycle already steers that decision.
    always_comb begin
        req   = pending | call_req;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (req[i] && (i > int'(cur_floor))) above = 1'b1;
            if (req[i] && (i < int'(cur_floor))) below = 1'b1;
        end
        ahead  = dir_up ? above : below;
        behind = dir_up ? below : above;

        here_call  = call_req[cur_floor];
        door_busy  = door_hold | here_call;
        next_floor = dir_up ? (cur_floor + FLOOR_W'(1)) : (cur_floor - FLOOR_W'(1));
        stop_next  = req[next_floor];

        step       = (state == MOVING) && timer_zero;
        open_here  = (state == IDLE) && here_call;
        start_idle = (state == IDLE) && !here_call && (ahead || behind);
        door_done  = (state == DOOR_OPEN) && timer_zero && !door_busy;

        // The timer reloads on every phase entry, on each floor passed without
        // stopping, and on every held door cycle; the door length wins whenever
        // the next phase is DOOR_OPEN.
        timer_load  = open_here | start_idle | step
                    | ((state == DOOR_OPEN) && door_busy)
                    | (door_done && (ahead || behind));
        timer_value = (open_here | (step && stop_next) | ((state == DOOR_OPEN) && door_busy))
                    ? DOOR_LOAD : TRAVEL_LOAD;

        // A call for the floor the car is standing at is served directly; only
        // while travelling does it get latched for a later visit.
        latch_mask = call_req;
        if (state != MOVING) latch_mask[cur_floor] = 1'b0;

        // Arrival at a stop clears that floor, overriding a same-cycle call.
        clear_mask = '0;
        if (step && stop_next) clear_mask[next_floor] = 1'b1;

        pending_next = (pending | latch_mask) & ~clear_mask;
    end

    elevator_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (emergency),
        .load       (timer_load),
        .en         (1'b1),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Scheduler FSM; all status outputs are registered alongside the state.
    always_ff @(posedge clk or posedge emergency) begin
        if (emergency) begin
            state     <= IDLE;
            cur_floor <= '0;
            dir_up    <= 1'b1;
            moving    <= 1'b0;
            door_open <= 1'b0;
            arrive    <= 1'b0;
            pending   <= '0;
        end else begin
            arrive  <= 1'b0;
            pending <= pending_next;
            case (state)
                IDLE: begin
                    if (here_call) begin
                        state     <= DOOR_OPEN;
                        door_open <= 1'b1;
                    end else if (ahead) begin
                        state  <= MOVING;
                        moving <= 1'b1;
                    end else if (behind) begin
                        state  <= MOVING;
                        moving <= 1'b1;
                        dir_up <= ~dir_up;
                    end
                end
                MOVING: begin
                    if (timer_zero) begin
                        cur_floor <= next_floor;
                        arrive    <= 1'b1;
                        if (stop_next) begin
                            state     <= DOOR_OPEN;
                            moving    <= 1'b0;
                            door_open <= 1'b1;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (door_done) begin
                        door_open <= 1'b0;
                        if (ahead) begin
                            state  <= MOVING;
                            moving <= 1'b1;
                        end else if (behind) begin
                            state  <= MOVING;
                            moving <= 1'b1;
                            dir_up <= ~dir_up;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    moving    <= 1'b0;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

    // SCAN only moves toward a pending call, so a step never leaves the shaft.
    floor_bounds_a: assert property (@(posedge clk) disable iff (emergency)
        step |-> (dir_up ? (cur_floor != FLOOR_W'(FLOORS - 1)) : (cur_floor != '0)));

    motion_door_exclusive_a: assert property (@(posedge clk) disable iff (emergency)
        !(moving && door_open));

endmodule

// File: tb/tb_elevator_scheduler.sv
// -----------------------------------------------------------------------------
// tb_elevator_scheduler
// Directed, table-driven bench for elevator_scheduler with the default
// TRAVEL_CYCLES = 8 and DOOR_CYCLES = 4, plus hand-written sequences for
// door hold and asynchronous emergency homing.
// -----------------------------------------------------------------------------
module tb_elevator_scheduler;
    import elevator_pkg::*;

    logic               clk = 1'b0;
    logic               emergency;
    logic [FLOORS-1:0]  call_req;
    logic               door_hold;
    logic [FLOOR_W-1:0] cur_floor;
    logic               dir_up;
    logic               moving;
    logic               door_open;
    logic               arrive;
    logic [FLOORS-1:0]  pending;

    typedef struct packed {
        logic [FLOOR_W-1:0] floor;
        logic               dir;
        logic               mov;
        logic               door;
        logic               arr;
        logic [FLOORS-1:0]  pend;
    } obs_t;

    typedef struct {
        logic              emerg;
        logic [FLOORS-1:0] call;
        int                cycles;
        obs_t              exp;
    } vec_t;

    int   tests_run    = 0;
    int   tests_failed = 0;
    vec_t vecs[$];

    elevator_scheduler dut (
        .clk       (clk),
        .emergency (emergency),
        .call_req  (call_req),
        .door_hold (door_hold),
        .cur_floor (cur_floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .arrive    (arrive),
        .pending   (pending)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic obs_t mk_obs(logic [FLOOR_W-1:0] f, logic d, logic m, logic o,
                                    logic a, logic [FLOORS-1:0] p);
        obs_t r;
        r.floor = f;
        r.dir   = d;
        r.mov   = m;
        r.door  = o;
        r.arr   = a;
        r.pend  = p;
        return r;
    endfunction

    function automatic vec_t mk(logic e, logic [FLOORS-1:0] c, int n, obs_t x);
        vec_t v;
        v.emerg  = e;
        v.call   = c;
        v.cycles = n;
        v.exp    = x;
        return v;
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input obs_t exp);
        obs_t got;
        got = mk_obs(cur_floor, dir_up, moving, door_open, arrive, pending);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got floor=%0d dir_up=%b moving=%b door_open=%b arrive=%b pending=%b, expected floor=%0d dir_up=%b moving=%b door_open=%b arrive=%b pending=%b",
                     name, got.floor, got.dir, got.mov, got.door, got.arr, got.pend,
                     exp.floor, exp.dir, exp.mov, exp.door, exp.arr, exp.pend);
        end
    endtask

    // Inputs are held for the whole row, then returned to zero.
    task automatic apply_stimulus(input vec_t v);
        emergency = v.emerg;
        call_req  = v.call;
        door_hold = 1'b0;
        repeat (v.cycles) tick();
        emergency = 1'b0;
        call_req  = '0;
    endtask

    initial begin
        emergency = 1'b1;
        call_req  = '0;
        door_hold = 1'b0;
        #12;
        check_output("reset_values", mk_obs(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000));
        emergency = 1'b0;
        tick();

        // Same-floor call at floor 0: door for exactly 4 cycles, never moves.
        vecs.push_back(mk(1'b0, 4'b0001, 1, mk_obs(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000)));
        vecs.push_back(mk(1'b0, 4'b0000, 1, mk_obs(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000)));
        vecs.push_back(mk(1'b0, 4'b0000, 1, mk_obs(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000)));
        vecs.push_back(mk(1'b0, 4'b0000, 1, mk_obs(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000)));
        vecs.push_back(mk(1'b0, 4'b0000, 1, mk_obs(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)));
        // Single call to floor 2: passes floor 1, stops at 2, back to idle.
        vecs.push_back(mk(1'b0, 4'b0100, 1, mk_obs(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100)));
        vecs.push_back(mk(1'b0, 4'b0000, 7, mk_obs(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100)));
        vecs.push_back(mk(1'b0, 4'b0000, 1, mk_obs(2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0100)));
        vecs.push_back(mk(1'b0, 4'b0000, 1, mk_obs(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100)));
        vecs.push_back(mk(1'b0, 4'b0000, 6, mk_obs(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100)));
        vecs.push_back(mk(1'b0, 4'b0000, 1, mk_obs(2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000)));
        vecs.push_back(mk(1'b0, 4'b0000, 3, mk_obs(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000)));
        vecs.push_back(mk(1'b0, 4'b0000, 1, mk_obs(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)));
        // Home the car, then the SCAN sequence 0 -> 3 with calls at 2 and 0.
        vecs.push_back(mk(1'b1, 4'b0000, 1, mk_obs(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)));
        vecs.push_back(mk(1'b0, 4'b1000, 1, mk_obs(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000)));
        vecs.push_back(mk(1'b0, 4'b0000, 8, mk_obs(2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1000)));
        vecs.push_back(mk(1'b0, 4'b0101, 1, mk_obs(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1101)));
        vecs.push_back(mk(1'b0, 4'b0000, 6, mk_obs(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1101)));
        vecs.push_back(mk(1'b0, 4'b0000, 1, mk_obs(2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1001)));
        vecs.push_back(mk(1'b0, 4'b0000, 3, mk_obs(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1001)));
        vecs.push_back(mk(1'b0, 4'b0000, 1, mk_obs(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001)));
        vecs.push_back(mk(1'b0, 4'b0000, 8, mk_obs(2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001)));
        vecs.push_back(mk(1'b0, 4'b0000, 4, mk_obs(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001)));
        vecs.push_back(mk(1'b0, 4'b0000, 8, mk_obs(2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001)));
        vecs.push_back(mk(1'b0, 4'b0000, 8, mk_obs(2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001)));
        vecs.push_back(mk(1'b0, 4'b0000, 8, mk_obs(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000)));
        vecs.push_back(mk(1'b0, 4'b0000, 4, mk_obs(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000)));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Door hold at floor 0 (dir down): held 10 cycles, then 4 more.
        call_req = 4'b0001;
        tick();
        call_req = '0;
        check_output("hold_open", mk_obs(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000));
        door_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output($sformatf("hold_high%0d", i), mk_obs(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000));
        end
        door_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("hold_tail%0d", i), mk_obs(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000));
        end
        tick();
        check_output("hold_close", mk_obs(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000));

        // Emergency mid-travel 2 -> 3 with calls pending at 3 and 0.
        call_req = 4'b0100;
        tick();
        call_req = '0;
        check_output("emg_reverse_start", mk_obs(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100));
        repeat (16) tick();
        check_output("emg_at_floor2", mk_obs(2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000));
        call_req = 4'b1001;
        tick();
        call_req = '0;
        repeat (3) tick();
        check_output("emg_departing", mk_obs(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001));
        tick();
        #2;
        emergency = 1'b1;
        #1;
        check_output("emg_async", mk_obs(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000));
        tick();
        emergency = 1'b0;
        check_output("emg_held", mk_obs(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000));
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output($sformatf("emg_after%0d", i), mk_obs(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
